current_overload_monitor: RTL
=============================

Name: current_overload_monitor

Overview:
Parametrised multi-channel successor to the two-channel current-sense overload detector. Each motor-driver current-sense line is synchronised and counted over a fixed measurement window, outside a blanking interval. The count is compared against a mode-dependent threshold (straight or turning). A per-channel trip/hold-off state machine drives registered overload flags to the H-bridge enable logic.

Parameters:
CHANNELS, 2, number of sense inputs (1..8)
CNT_W, 28, width of window and accumulator counters
WINDOW, 20000000, measurement window length in clock cycles (BLANK_CYCLES < WINDOW <= 2^CNT_W)
BLANK_CYCLES, 25, cycles at start of each window not counted
THRESH_STRAIGHT, 500000, active-cycle limit when is_turning=0
THRESH_TURN, 2000000, active-cycle limit when is_turning=1
TRIP_WINDOWS, 1, consecutive over-limit windows required to trip (>=1)
HOLDOFF_WINDOWS, 2, minimum window ends a channel stays tripped before release
SYNC_STAGES, 2, synchroniser depth on sense inputs (>=2)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
sense  input  CHANNELS  asynchronous current-sense lines, high = current above comparator level
is_turning  input  1  synchronous mode select, sampled at window end
enable  input  1  monitor enable; low = idle and clear
clear_trip  input  1  one-cycle pulse, force all channels to OK
ch_sel  input  3  channel select for ch_count
overload  output  1  OR of overload_ch
overload_ch  output  CHANNELS  per-channel tripped flag
window_done  output  1  one-cycle pulse after each window evaluation
ch_count  output  CNT_W  last completed-window count of channel ch_sel (0 if ch_sel >= CHANNELS)

Behaviour:
- Reset (reset_n low, asynchronous): synchronisers, window counter, accumulators, streak and hold-off counters, and stored counts go to 0. All channel states go to OK. overload, overload_ch and window_done go to 0.
- Synchroniser: SYNC_STAGES flops per channel. Sample s[i] = last stage. Latency is SYNC_STAGES cycles.
- Window counter win runs 0..WINDOW-1 and wraps to 0 when enable=1.
- enable=0: win, accumulators and streaks are held at 0. All states are forced to OK, so overload_ch=0. window_done=0.
- Accumulate: when BLANK_CYCLES <= win <= WINDOW-1 and s[i]=1, acc[i] increments. acc[i] saturates at 2^CNT_W-1 and never wraps.
- Window end (win=WINDOW-1):
  - final[i] = acc[i] + s[i], saturated.
  - over[i] = final[i] > THR, strict. THR = THRESH_TURN if is_turning else THRESH_STRAIGHT.
  - final[i] is stored for ch_count. acc[i] is cleared, so the next window starts at 0.
- Per-channel FSM, evaluated only at window end:
  - OK, over: streak++. If streak reaches TRIP_WINDOWS, go to TRIPPED, load holdoff=HOLDOFF_WINDOWS, streak=0.
  - OK, not over: streak=0.
  - TRIPPED, holdoff>0: holdoff--, stay TRIPPED (over or not).
  - TRIPPED, holdoff=0, over: reload holdoff, stay TRIPPED.
  - TRIPPED, holdoff=0, not over: go to OK.
- Outputs are registered. overload_ch, overload, ch_count and window_done reflect a window end one cycle after win=WINDOW-1. window_done is high for exactly that cycle.
- clear_trip has priority over a simultaneous window end. All states go to OK and streaks and holdoff clear. Accumulators and win are unaffected. The over result of that window end is discarded.
- Channels are fully independent. Simultaneous trips are all reported in the same cycle.
- ch_sel is combinational onto the stored counts; no added latency.

Test Plan:
Bench parameters: CHANNELS=2, WINDOW=100, BLANK_CYCLES=5, THRESH_STRAIGHT=20, THRESH_TURN=60, TRIP_WINDOWS=2, HOLDOFF_WINDOWS=1, CNT_W=8.
1. sense[0] held high continuously, is_turning=0 -> ch_count(ch_sel=0)=95 each window. overload_ch=00 after 1st window_done, 01 after 2nd. overload=1.
2. Threshold edge: sample high for exactly 20 counted cycles -> no over, streak stays 0. Exactly 21 cycles for two windows -> trip on 2nd window_done.
3. Mode: is_turning=1, sense[1] high 60 counted cycles for 3 windows -> no trip. 61 cycles for 2 windows -> overload_ch=10.
4. Release: trip ch0, then sense low -> still tripped after 1st clean window (holdoff 1->0), overload_ch=00 after 2nd clean window. Over-limit window at holdoff=0 -> stays tripped.
5. clear_trip coincident with tripping window end -> overload_ch=00 next cycle, and the next single over window does not trip (streak=0).
6. reset_n low mid-window for 1 cycle -> all outputs 0 immediately, win restarts at 0. enable=0 while tripped -> overload=0, no window_done until re-enabled.

Source files
------------

// File: rtl/current_overload_monitor_if.sv
// Signal bundle between the H-bridge controller and the current overload monitor.
// The monitor side is the slave; the controller/bench side is the master.
interface current_overload_monitor_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 28
);
  logic [CHANNELS-1:0] sense;
  logic                is_turning;
  logic                enable;
  logic                clear_trip;
  logic [2:0]          ch_sel;
  logic                overload;
  logic [CHANNELS-1:0] overload_ch;
  logic                window_done;
  logic [CNT_W-1:0]    ch_count;

  modport master (
    output sense, is_turning, enable, clear_trip, ch_sel,
    input  overload, overload_ch, window_done, ch_count
  );

  modport slave (
    input  sense, is_turning, enable, clear_trip, ch_sel,
    output overload, overload_ch, window_done, ch_count
  );
endinterface

// File: rtl/current_overload_monitor.sv
// Multi-channel current-sense overload monitor: windowed duty counting against a
// mode-dependent threshold, with a per-channel trip/hold-off state machine.
module current_overload_monitor #(
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned CNT_W           = 28,
  parameter int unsigned WINDOW          = 20000000,
  parameter int unsigned BLANK_CYCLES    = 25,
  parameter int unsigned THRESH_STRAIGHT = 500000,
  parameter int unsigned THRESH_TURN     = 2000000,
  parameter int unsigned TRIP_WINDOWS    = 1,
  parameter int unsigned HOLDOFF_WINDOWS = 2,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input logic                         clock,
  input logic                         reset_n,
  current_overload_monitor_if.slave   mon
);

  localparam int unsigned StreakW = (TRIP_WINDOWS < 2) ? 1 : $clog2(TRIP_WINDOWS + 1);
  localparam int unsigned HoldW   = (HOLDOFF_WINDOWS < 1) ? 1 : $clog2(HOLDOFF_WINDOWS + 1);

  localparam logic [CNT_W-1:0]   WinLast     = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]   BlankStart  = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0]   ThrStraight = CNT_W'(THRESH_STRAIGHT);
  localparam logic [CNT_W-1:0]   ThrTurn     = CNT_W'(THRESH_TURN);
  localparam logic [HoldW-1:0]   HoldLoad    = HoldW'(HOLDOFF_WINDOWS);

  typedef enum logic {StOk, StTripped} state_e;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    acc_q [CHANNELS];
  logic [CNT_W-1:0]    acc_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [StreakW-1:0]  streak_q [CHANNELS];
  logic [StreakW-1:0]  streak_d [CHANNELS];
  logic [HoldW-1:0]    hold_q [CHANNELS];
  logic [HoldW-1:0]    hold_d [CHANNELS];
  logic                done_q, done_d;

  logic [CHANNELS-1:0] s;
  logic                win_end;
  logic                in_count;
  logic [CNT_W-1:0]    thr;
  logic [CNT_W-1:0]    final_cnt [CHANNELS];
  logic [CHANNELS-1:0] over;
  logic [CHANNELS-1:0] tripped;

  always_comb begin
    sync_d[0] = mon.sense;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign win_end  = mon.enable && (win_q == WinLast);
  assign in_count = (win_q >= BlankStart);
  assign thr      = mon.is_turning ? ThrTurn : ThrStraight;

  // final_cnt doubles as the running accumulator update; at the last window cycle it
  // already includes that cycle's sample.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      final_cnt[i] = (in_count && s[i] && !(&acc_q[i])) ? acc_q[i] + CNT_W'(1) : acc_q[i];
      over[i]      = (final_cnt[i] > thr);
    end
  end

  always_comb begin
    win_d  = '0;
    done_d = win_end;
    if (mon.enable && !win_end) begin
      win_d = win_q + CNT_W'(1);
    end
    for (int i = 0; i < CHANNELS; i++) begin
      acc_d[i]    = final_cnt[i];
      cnt_d[i]    = cnt_q[i];
      state_d[i]  = state_q[i];
      streak_d[i] = streak_q[i];
      hold_d[i]   = hold_q[i];
      if (!mon.enable) begin
        acc_d[i]    = '0;
        state_d[i]  = StOk;
        streak_d[i] = '0;
        hold_d[i]   = '0;
      end else begin
        if (win_end) begin
          cnt_d[i] = final_cnt[i];
          acc_d[i] = '0;
        end
        // clear_trip wins over the window-end evaluation and discards its result.
        if (mon.clear_trip) begin
          state_d[i]  = StOk;
          streak_d[i] = '0;
          hold_d[i]   = '0;
        end else if (win_end) begin
          unique case (state_q[i])
            StOk: begin
              if (!over[i]) begin
                streak_d[i] = '0;
              end else if ((32'(streak_q[i]) + 32'd1) >= TRIP_WINDOWS) begin
                state_d[i]  = StTripped;
                hold_d[i]   = HoldLoad;
                streak_d[i] = '0;
              end else begin
                streak_d[i] = streak_q[i] + StreakW'(1);
              end
            end
            StTripped: begin
              if (hold_q[i] != '0) begin
                hold_d[i] = hold_q[i] - HoldW'(1);
              end else if (over[i]) begin
                hold_d[i] = HoldLoad;
              end else begin
                state_d[i] = StOk;
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]    <= '0;
        cnt_q[i]    <= '0;
        state_q[i]  <= StOk;
        streak_q[i] <= '0;
        hold_q[i]   <= '0;
      end
      win_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      streak_q <= streak_d;
      hold_q   <= hold_d;
      win_q    <= win_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    mon.ch_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      tripped[i] = (state_q[i] == StTripped);
      if (mon.ch_sel == 3'(i)) begin
        mon.ch_count = cnt_q[i];
      end
    end
  end

  assign mon.overload_ch = tripped;
  assign mon.overload    = |tripped;
  assign mon.window_done = done_q;

endmodule
